// File: rtl/program_loader.sv
// Serial program loader: receives a MAGIC/count/data/checksum byte frame and
// writes the assembled instruction words into instruction memory, holding the CPU meanwhile.
module program_loader #(
   parameter int unsigned INSTRUCTION_WIDTH = 32,
   parameter int unsigned PC_WIDTH          = 8,
   parameter logic [7:0]  MAGIC             = 8'hA5
) (
   input  logic                         clock,
   input  logic                         isResetN,
   input  logic [7:0]                   byteIn,
   input  logic                         byteValid,
   output logic                         byteReady,
   output logic                         writeEnable,
   output logic [PC_WIDTH-1:0]          writeAddress,
   output logic [INSTRUCTION_WIDTH-1:0] writeData,
   output logic                         cpuHold,
   output logic                         loadDone,
   output logic                         loadError
);

   localparam int unsigned BYTES = INSTRUCTION_WIDTH / 8;
   localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_WRITE,
      S_CHECK
   } state_t;

   state_t                         r_state;
   state_t                         w_state_next;
   logic [7:0]                     r_count;
   logic [7:0]                     r_instr;
   logic [PC_WIDTH-1:0]            r_index;
   logic [BW-1:0]                  r_byte_cnt;
   logic [7:0]                     r_csum;
   logic [INSTRUCTION_WIDTH-1:0]   r_word;
   logic                           r_byte_ready;
   logic                           r_we;
   logic [PC_WIDTH-1:0]            r_waddr;
   logic [INSTRUCTION_WIDTH-1:0]   r_wdata;
   logic                           r_hold;
   logic                           r_done;
   logic                           r_err;

   logic                           w_accept;
   logic                           w_last_byte;
   logic                           w_last_instr;
   logic [INSTRUCTION_WIDTH-1:0]   w_word;

   assign w_accept     = byteValid & r_byte_ready;
   assign w_last_byte  = (r_byte_cnt == BW'(BYTES - 1));
   // r_instr counts instructions independently of the (possibly narrower) address
   assign w_last_instr = (({1'b0, r_instr} + 9'd1) == {1'b0, r_count});

   // Assembly register with the incoming byte merged at the current byte position
   always_comb begin
      w_word = r_word;
      w_word[{r_byte_cnt, 3'b000} +: 8] = byteIn;
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && (byteIn == MAGIC)) w_state_next = S_COUNT;
         S_COUNT: if (w_accept) w_state_next = (byteIn == 8'd0) ? S_CHECK : S_DATA;
         S_DATA:  if (w_accept && w_last_byte) w_state_next = S_WRITE;
         S_WRITE: w_state_next = w_last_instr ? S_CHECK : S_DATA;
         S_CHECK: if (w_accept) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge isResetN) begin
      if (!isResetN) r_state <= S_IDLE;
      else           r_state <= w_state_next;
   end

   // Datapath, counters and registered outputs
   always_ff @(posedge clock or negedge isResetN) begin
      if (!isResetN) begin
         r_count      <= '0;
         r_instr      <= '0;
         r_index      <= '0;
         r_byte_cnt   <= '0;
         r_csum       <= '0;
         r_word       <= '0;
         r_byte_ready <= 1'b1;
         r_we         <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_hold       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_byte_ready <= (w_state_next != S_WRITE);
         r_we         <= (w_state_next == S_WRITE);
         case (r_state)
            S_IDLE: begin
               if (w_accept && (byteIn == MAGIC)) begin
                  r_hold <= 1'b1;
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
               end
            end
            S_COUNT: begin
               if (w_accept) begin
                  r_count    <= byteIn;
                  r_instr    <= '0;
                  r_index    <= '0;
                  r_csum     <= '0;
                  r_byte_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_word     <= w_word;
                  r_csum     <= r_csum ^ byteIn;
                  r_byte_cnt <= r_byte_cnt + BW'(1);
                  if (w_last_byte) begin
                     r_waddr <= r_index;
                     r_wdata <= w_word;
                  end
               end
            end
            S_WRITE: begin
               r_index    <= r_index + PC_WIDTH'(1);
               r_instr    <= r_instr + 8'd1;
               r_byte_cnt <= '0;
            end
            S_CHECK: begin
               if (w_accept) begin
                  if (byteIn == r_csum) begin
                     r_hold <= 1'b0;
                     r_done <= 1'b1;
                  end else begin
                     r_err  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign byteReady    = r_byte_ready;
   assign writeEnable  = r_we;
   assign writeAddress = r_waddr;
   assign writeData    = r_wdata;
   assign cpuHold      = r_hold;
   assign loadDone     = r_done;
   assign loadError    = r_err;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, default 32; width of one instruction word; SHALL be a multiple of 8.
REQ-002 Parameter PC_WIDTH, default 8; width of the instruction-memory write address.
REQ-003 Parameter MAGIC, default 8'hA5; header byte that starts a load.
REQ-004 Port clock  input  1  sole clock; all state changes on rising edge.
REQ-005 Port isResetN  input  1  asynchronous, active-low reset.
REQ-006 Port byteIn  input  8  incoming program byte.
REQ-007 Port byteValid  input  1  byteIn holds a valid byte.
REQ-008 Port byteReady  output  1  loader can accept a byte; transfer occurs on a clock edge where byteValid & byteReady.
REQ-009 Port writeEnable  output  1  one-cycle write strobe to instruction memory.
REQ-010 Port writeAddress  output  PC_WIDTH  instruction-memory word address.
REQ-011 Port writeData  output  INSTRUCTION_WIDTH  assembled instruction.
REQ-012 Port cpuHold  output  1  holds the CPU in reset while high (ORed into CPU reset).
REQ-013 Port loadDone  output  1  last load completed with a good checksum.
REQ-014 Port loadError  output  1  last load failed its checksum.

Function
REQ-015 Frame SHALL be: MAGIC, count byte N (instructions, 0..255), N*(INSTRUCTION_WIDTH/8) data bytes least-significant byte first, one checksum byte.
REQ-016 FSM states SHALL be IDLE, COUNT, DATA, WRITE, CHECK; loadDone/loadError are registered flags, not states.
REQ-017 IDLE: byteReady=1; accepted byte == MAGIC -> COUNT, cpuHold<=1, loadDone<=0, loadError<=0; any other byte discarded, stay IDLE.
REQ-018 COUNT: byteReady=1; accepted byte latched as N, index<=0, checksum<=0, byte counter<=0; N==0 -> CHECK, else DATA.
REQ-019 DATA: byteReady=1; each accepted byte shifted into the assembly register at position byte counter and XORed into checksum; after the (INSTRUCTION_WIDTH/8)th byte -> WRITE.
REQ-020 WRITE: exactly one cycle; byteReady=0; writeEnable=1, writeAddress=index, writeData=assembled word; index increments; byte counter clears; index+1==N -> CHECK, else DATA.
REQ-021 writeEnable SHALL be 0 in every state other than WRITE; writeAddress/writeData hold last values otherwise.
REQ-022 CHECK: byteReady=1; accepted byte == checksum -> IDLE, cpuHold<=0, loadDone<=1; mismatch -> IDLE, cpuHold stays 1, loadError<=1.
REQ-023 Load latency: one cycle per accepted byte plus one WRITE cycle per instruction; first write occurs the cycle after the last byte of instruction 0 is accepted.
REQ-024 While cpuHold=1 after an error, only a new good load SHALL release it.
REQ-025 A MAGIC byte arriving in COUNT/DATA/CHECK SHALL be treated as ordinary data (no resynchronisation).
REQ-026 byteValid low in any state SHALL stall the FSM with no state, counter or checksum change.
REQ-027 index SHALL be PC_WIDTH bits; if N exceeds 2^PC_WIDTH, writeAddress wraps modulo 2^PC_WIDTH.
REQ-028 Checksum SHALL cover data bytes only, not MAGIC, N or the checksum byte.

Reset
REQ-029 isResetN low SHALL immediately force state IDLE, byteReady=1, writeEnable=0, writeAddress=0, writeData=0, cpuHold=0, loadDone=0, loadError=0, all counters and checksum 0.
REQ-030 Reset asserted mid-load SHALL abandon the frame; partially written memory is not cleaned; cpuHold returns to 0.
REQ-031 After isResetN rises, the first rising edge SHALL already accept a byte in IDLE.

Verification
REQ-032 Good load, INSTRUCTION_WIDTH=32: A5,02,11,22,33,44,55,66,77,88,checksum 88 -> writes 0x44332211@0 then 0x88776655@1, one writeEnable pulse each, loadDone=1, cpuHold=0.
REQ-033 Bad checksum: same frame, checksum 00 -> both writes occur, loadError=1, loadDone=0, cpuHold remains 1.
REQ-034 Empty program: A5,00,00 -> no writeEnable, loadDone=1; A5,00,01 -> loadError=1.
REQ-035 Garbage and stalls: 00,FF,A5,01 then data bytes with byteValid toggled every other cycle -> leading bytes discarded, single correct write at address 0, byteReady=0 only in WRITE cycle.
REQ-036 Reset mid-load: assert isResetN=0 after 3 data bytes -> all outputs reset values immediately; fresh good frame afterwards loads normally.
REQ-037 Recovery: bad load followed by a good load -> cpuHold stays 1 through both until good checksum, then 0; loadError cleared at second MAGIC.
